bin_bcd_seg_display: RTL and testbench

Converts a 6-bit binary value (0..63) into two packed BCD digits and drives two 7-segment digit outputs.
- seg[6:0] shows the ones digit; seg[13:7] shows the tens digit.
- Sits between the seconds counter and the board's HEX displays.
- Conversion and segment decode are combinational internally; bcd and seg are registered.

---
 rtl/bin_bcd_seg_display.sv | 113 +++++++++++
 tb/tb_bin_bcd_seg_display.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bin_bcd_seg_display.sv
// bin_bcd_seg_display: converts a 6-bit binary value (0..63) into two packed
// BCD digits and drives two 7-segment digit patterns. Conversion and decode
// are combinational; both outputs are registered, so there is one cycle of
// latency from bin to bcd/seg.
//
// Parameters:
//   ACTIVE_LOW         1 = segment lit when its bit is 0, 0 = lit when 1
//   BLANK_LEADING_ZERO 1 = tens digit shows all segments off when tens = 0
//
// Ports:
//   clk  in   1   system clock, rising edge
//   rst  in   1   asynchronous, active-high reset
//   bin  in   6   unsigned value to display, 0..63
//   bcd  out  8   registered packed BCD, [7:4] tens, [3:0] ones
//   seg  out  14  registered segments, [6:0] ones digit, [13:7] tens digit,
//                 within each digit bit0 = a .. bit6 = g
module bin_bcd_seg_display #(
    parameter bit ACTIVE_LOW         = 1'b1,
    parameter bit BLANK_LEADING_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  bin,
    output logic [7:0]  bcd,
    output logic [13:0] seg
);

    localparam int unsigned BIN_W   = 6;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned BCD_W   = 2 * DIGIT_W;
    localparam int unsigned DD_W    = BCD_W + BIN_W;

    // Table codes are stored active-low; XOR with this mask flips polarity.
    localparam logic [SEG_W-1:0] POL_MASK  = ACTIVE_LOW ? 7'h00 : 7'h7F;
    localparam logic [SEG_W-1:0] SEG_ZERO  = 7'h40 ^ POL_MASK;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F ^ POL_MASK;
    localparam logic [SEG_W-1:0] RST_TENS  = BLANK_LEADING_ZERO ? SEG_BLANK : SEG_ZERO;
    localparam logic [SEG_W-1:0] RST_ONES  = SEG_ZERO;

    // Full-hex decoder, active-low codes (g..a). A-F are kept so the decoder
    // stays reusable even though the BCD path never reaches them.
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [DIGIT_W-1:0] d);
        logic [SEG_W-1:0] code;
        code = 7'h7F;
        case (d)
            4'h0: code = 7'h40;
            4'h1: code = 7'h79;
            4'h2: code = 7'h24;
            4'h3: code = 7'h30;
            4'h4: code = 7'h19;
            4'h5: code = 7'h12;
            4'h6: code = 7'h02;
            4'h7: code = 7'h78;
            4'h8: code = 7'h00;
            4'h9: code = 7'h10;
            4'hA: code = 7'h08;
            4'hB: code = 7'h03;
            4'hC: code = 7'h46;
            4'hD: code = 7'h21;
            4'hE: code = 7'h06;
            4'hF: code = 7'h0E;
            default: code = 7'h7F;
        endcase
        return code;
    endfunction

    logic [DD_W-1:0]    dd_c;
    logic [BCD_W-1:0]   bcd_c;
    logic [DIGIT_W-1:0] tens_c;
    logic [DIGIT_W-1:0] ones_c;
    logic [SEG_W-1:0]   tens_seg_c;
    logic [SEG_W-1:0]   ones_seg_c;

    // Double dabble: add 3 to any BCD nibble >= 5, then shift, once per bin bit.
    // The tens nibble never exceeds 6, so [13:10] cannot overflow.
    always_comb begin
        dd_c = DD_W'({BCD_W'(0), bin});
        for (int i = 0; i < int'(BIN_W); i++) begin
            if (dd_c[9:6] >= 4'd5) begin
                dd_c[9:6] = dd_c[9:6] + 4'd3;
            end
            if (dd_c[13:10] >= 4'd5) begin
                dd_c[13:10] = dd_c[13:10] + 4'd3;
            end
            dd_c = dd_c << 1;
        end
        bcd_c  = dd_c[DD_W-1:BIN_W];
        tens_c = bcd_c[7:4];
        ones_c = bcd_c[3:0];
    end

    // Per-digit decode with polarity and optional leading-zero blanking.
    always_comb begin
        ones_seg_c = hex_to_seg(ones_c) ^ POL_MASK;
        tens_seg_c = hex_to_seg(tens_c) ^ POL_MASK;
        if (BLANK_LEADING_ZERO && (tens_c == 4'd0)) begin
            tens_seg_c = SEG_BLANK;
        end
    end

    // Output registers; reset shows "00" (or " 0" when blanking).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd <= BCD_W'(0);
            seg <= {RST_TENS, RST_ONES};
        end else begin
            bcd <= bcd_c;
            seg <= {tens_seg_c, ones_seg_c};
        end
    end

endmodule

// File: tb/tb_bin_bcd_seg_display.sv
module tb_bin_bcd_seg_display;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  bin = 6'd0;
    logic [7:0]  bcd0, bcd1, bcd2;
    logic [13:0] seg0, seg1, seg2;

    int total = 0;
    int bad   = 0;

    // dut0: defaults; dut1: leading zero blanked; dut2: active-high segments
    bin_bcd_seg_display dut0 (.clk(clk), .rst(rst), .bin(bin), .bcd(bcd0), .seg(seg0));
    bin_bcd_seg_display #(.BLANK_LEADING_ZERO(1'b1)) dut1
        (.clk(clk), .rst(rst), .bin(bin), .bcd(bcd1), .seg(seg1));
    bin_bcd_seg_display #(.ACTIVE_LOW(1'b0)) dut2
        (.clk(clk), .rst(rst), .bin(bin), .bcd(bcd2), .seg(seg2));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  bcd;
        logic [13:0] s0;
        logic [13:0] s1;
        logic [13:0] s2;
    } exp_t;

    exp_t q[$];

    // Active-low digit codes g..a, transcribed from the decode table.
    logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic exp_t model(input int v, input string nm);
        exp_t e;
        int t, o;
        t = v / 10;
        o = v % 10;
        e.name = nm;
        e.bcd  = {4'(t), 4'(o)};
        e.s0   = {lut[t], lut[o]};
        e.s1   = {(t == 0) ? 7'h7F : lut[t], lut[o]};
        e.s2   = ~e.s0;
        return e;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    task automatic check_all(input exp_t e);
        cmp({e.name, " bcd0"}, 32'(bcd0), 32'(e.bcd));
        cmp({e.name, " bcd1"}, 32'(bcd1), 32'(e.bcd));
        cmp({e.name, " seg0"}, 32'(seg0), 32'(e.s0));
        cmp({e.name, " seg1"}, 32'(seg1), 32'(e.s1));
        cmp({e.name, " seg2"}, 32'(seg2), 32'(e.s2));
    endtask

    // Reset state for all three variants, hand-computed.
    task automatic check_reset(input string nm);
        exp_t e;
        e.name = nm;
        e.bcd  = 8'h00;
        e.s0   = {7'h40, 7'h40};
        e.s1   = {7'h7F, 7'h40};
        e.s2   = {7'h3F, 7'h3F};
        check_all(e);
        cmp({nm, " bcd2"}, 32'(bcd2), 32'h00);
    endtask

    // Apply a value at the falling edge and queue what the next rising edge must show.
    task automatic drive_model(input int v);
        @(negedge clk);
        bin = 6'(v);
        q.push_back(model(v, $sformatf("bin=%0d", v)));
    endtask

    task automatic drive_exp(input int v, input logic [7:0] b, input logic [13:0] s0,
                             input logic [13:0] s1, input logic [13:0] s2);
        exp_t e;
        @(negedge clk);
        bin    = 6'(v);
        e.name = $sformatf("dir bin=%0d", v);
        e.bcd  = b;
        e.s0   = s0;
        e.s1   = s1;
        e.s2   = s2;
        q.push_back(e);
    endtask

    // Monitor: one registered result per rising edge while expectations are pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_all(e);
            end
        end
    end

    initial begin
        exp_t e;
        int   waited;
        // Reset with bin=37 before any clock edge.
        bin = 6'd37;
        #1 rst = 1'b1;
        #1 check_reset("rst_noclk");
        @(posedge clk);
        #2 check_reset("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        e.name = "first 37";
        e.bcd  = 8'h37;
        e.s0   = {7'h30, 7'h78};
        e.s1   = {7'h30, 7'h78};
        e.s2   = {7'h4F, 7'h07};
        q.push_back(e);

        // Exhaustive sweep, one value per cycle.
        for (int v = 0; v < 64; v++) drive_model(v);

        // Hand-computed boundaries.
        drive_exp(0,  8'h00, {7'h40, 7'h40}, {7'h7F, 7'h40}, {7'h3F, 7'h3F});
        drive_exp(9,  8'h09, {7'h40, 7'h10}, {7'h7F, 7'h10}, {7'h3F, 7'h6F});
        drive_exp(10, 8'h10, {7'h79, 7'h40}, {7'h79, 7'h40}, {7'h06, 7'h3F});
        drive_exp(59, 8'h59, 14'b0010010_0010000, 14'b0010010_0010000, 14'b1101101_1101111);
        drive_exp(63, 8'h63, {7'h02, 7'h30}, {7'h02, 7'h30}, {7'h7D, 7'h4F});
        drive_exp(5,  8'h05, {7'h40, 7'h12}, {7'h7F, 7'h12}, {7'h3F, 7'h6D});
        drive_exp(8,  8'h08, {7'h40, 7'h00}, {7'h7F, 7'h00}, {7'h3F, 7'h7F});
        drive_exp(42, 8'h42, {7'h19, 7'h24}, {7'h19, 7'h24}, {7'h66, 7'h5B});

        // Short reset pulse between edges while bin=42.
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset("rst_pulse");
        #1 rst = 1'b0;
        #0.5 check_reset("rst_after_release");
        e.name = "reload 42";
        e.bcd  = 8'h42;
        e.s0   = {7'h19, 7'h24};
        e.s1   = {7'h19, 7'h24};
        e.s2   = {7'h66, 7'h5B};
        q.push_back(e);

        drive_model(17);
        drive_model(60);

        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #3;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
